// File: rtl/dpc_video_pkg.sv
// rtl/dpc_video_pkg.sv - shared types for the raster video source
// Purpose: FSM state encodings and test-pattern codes used by axis_video_src
//          and video_pattern_gen.
// Ports:   none (package).
package dpc_video_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    PAT_HRAMP   = 2'd0,
    PAT_VRAMP   = 2'd1,
    PAT_CHECKER = 2'd2,
    PAT_FLAT    = 2'd3
  } pattern_t;

endpackage

// File: rtl/axis_video_src_if.sv
// rtl/axis_video_src_if.sv - AXI4-Stream video beat bundle
// Purpose: groups the pixel stream handshake and sideband signals.
// Ports:   none; signals tvalid/tready/tdata/tuser/tlast.
//          master: drives tvalid/tdata/tuser/tlast, receives tready.
//          slave:  receives tvalid/tdata/tuser/tlast, drives tready.
interface axis_video_src_if #(
  parameter int WIDTH = 8
);
  logic             tvalid;
  logic             tready;
  logic [WIDTH-1:0] tdata;
  logic             tuser;
  logic             tlast;

  modport master (output tvalid, output tdata, output tuser, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tuser, input tlast, output tready);
endinterface

// File: rtl/video_pattern_gen.sv
// rtl/video_pattern_gen.sv - combinational pixel generator
// Purpose: maps a raster coordinate and pattern code to a pixel value,
//          with an optional single-pixel all-ones override.
// Ports:   h, v          raster coordinate (pixel, line)
//          pattern       pattern code (h-ramp, v-ramp, checker, flat)
//          inj_en        override enable
//          inj_h, inj_v  coordinate of the overridden pixel
//          pixel         generated pixel value
module video_pattern_gen
  import dpc_video_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 10
) (
  input  logic [CNT_WIDTH-1:0] h,
  input  logic [CNT_WIDTH-1:0] v,
  input  pattern_t             pattern,
  input  logic                 inj_en,
  input  logic [CNT_WIDTH-1:0] inj_h,
  input  logic [CNT_WIDTH-1:0] inj_v,
  output logic [WIDTH-1:0]     pixel
);

  always_comb begin
    pixel = '0;
    if (inj_en && (h == inj_h) && (v == inj_v)) begin
      pixel = '1;
    end else begin
      case (pattern)
        PAT_HRAMP:   pixel = WIDTH'(h);
        PAT_VRAMP:   pixel = WIDTH'(v);
        PAT_CHECKER: pixel = {WIDTH{h[0] ^ v[0]}};
        PAT_FLAT:    pixel = WIDTH'(1) << (WIDTH - 1);
        default:     pixel = '0;
      endcase
    end
  end

endmodule

// File: rtl/axis_video_src.sv
// rtl/axis_video_src.sv - AXI4-Stream raster video source
// Purpose: emits ROW x COL frames of synthetic pixels with tuser on the
//          first pixel of a frame and tlast on the last pixel of a line.
//          Started/stopped by a level 'go'; stops only at frame boundaries.
// Ports:   axis_aclk     clock
//          axis_aresetn  asynchronous active-low reset
//          go            run request level (may be asynchronous)
//          pattern_sel   0 h-ramp, 1 v-ramp, 2 checker, 3 flat
//          m_axis        pixel stream (master modport)
//          frame_cnt     completed frames, wraps
//          busy          high while the FSM is not idle
// Option:  DPC_SRC_DEAD_PIXEL_INJECT_EN adds inj_en/inj_hcnt/inj_vcnt, which
//          force one pixel per frame to all-ones.
module axis_video_src
  import dpc_video_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int ROW       = 6,
  parameter int COL       = 8,
  parameter int CNT_WIDTH = 10
) (
  input  logic                 axis_aclk,
  input  logic                 axis_aresetn,
  input  logic                 go,
  input  logic [1:0]           pattern_sel,
`ifdef DPC_SRC_DEAD_PIXEL_INJECT_EN
  input  logic                 inj_en,
  input  logic [CNT_WIDTH-1:0] inj_hcnt,
  input  logic [CNT_WIDTH-1:0] inj_vcnt,
`endif
  axis_video_src_if.master     m_axis,
  output logic [CNT_WIDTH-1:0] frame_cnt,
  output logic                 busy
);

  localparam logic [CNT_WIDTH-1:0] H_LAST = CNT_WIDTH'(COL - 1);
  localparam logic [CNT_WIDTH-1:0] V_LAST = CNT_WIDTH'(ROW - 1);

  logic                 go_a, go_b;
  logic                 rise, fall;
  state_t               state_q, state_d;
  logic                 gen_en;
  logic [CNT_WIDTH-1:0] hcnt, vcnt;
  logic [CNT_WIDTH-1:0] h_step, v_step;
  logic [CNT_WIDTH-1:0] ld_h, ld_v;
  logic                 accept, last_px, load, frame_start;
  pattern_t             pat_q, pat_cur;
  logic                 inj_en_cur;
  logic [CNT_WIDTH-1:0] inj_h_cur, inj_v_cur;
  logic [WIDTH-1:0]     pixel;

  // go synchroniser
  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      go_a <= 1'b0;
      go_b <= 1'b0;
    end else begin
      go_a <= go;
      go_b <= go_a;
    end
  end

  assign rise = go_a & ~go_b;
  assign fall = ~go_a & go_b;

  assign accept  = m_axis.tvalid & m_axis.tready;
  assign last_px = (hcnt == H_LAST) && (vcnt == V_LAST);

  // hcnt/vcnt name the pixel in the output register (or the next one to load
  // when the register is empty); h_step/v_step is its raster successor.
  always_comb begin
    h_step = (hcnt == H_LAST) ? '0 : hcnt + CNT_WIDTH'(1);
    v_step = vcnt;
    if (hcnt == H_LAST) begin
      v_step = (vcnt == V_LAST) ? '0 : vcnt + CNT_WIDTH'(1);
    end
  end

  // A load into an occupied register only happens on accept, so it takes the
  // successor; into an empty register it takes the current position.
  assign ld_h = m_axis.tvalid ? h_step : hcnt;
  assign ld_v = m_axis.tvalid ? v_step : vcnt;

  // FSM: state register
  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (rise) state_d = S_RUN;
      S_RUN:   if (fall) state_d = S_DRAIN;
      S_DRAIN: begin
        if (rise) begin
          state_d = S_RUN;
        end else if (accept && last_px) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_DRAIN;
    endcase
  end

  // FSM: outputs. While draining, the pixel after the frame's last one must
  // not be loaded, otherwise a new frame would leak out after stop.
  always_comb begin
    busy   = 1'b1;
    gen_en = 1'b0;
    case (state_q)
      S_IDLE:  busy = 1'b0;
      S_RUN:   gen_en = 1'b1;
      S_DRAIN: gen_en = ~(accept & last_px);
      default: gen_en = 1'b0;
    endcase
  end

  assign load        = gen_en & (~m_axis.tvalid | m_axis.tready);
  assign frame_start = load && (ld_h == '0) && (ld_v == '0);

  // Per-frame settings are captured as pixel (0,0) loads; that pixel itself
  // uses the live inputs since the latch updates on the same edge.
  assign pat_cur = frame_start ? pattern_t'(pattern_sel) : pat_q;

  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      pat_q <= PAT_HRAMP;
    end else if (frame_start) begin
      pat_q <= pattern_t'(pattern_sel);
    end
  end

`ifdef DPC_SRC_DEAD_PIXEL_INJECT_EN
  logic                 inj_en_q;
  logic [CNT_WIDTH-1:0] inj_h_q, inj_v_q;

  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      inj_en_q <= 1'b0;
      inj_h_q  <= '0;
      inj_v_q  <= '0;
    end else if (frame_start) begin
      inj_en_q <= inj_en;
      inj_h_q  <= inj_hcnt;
      inj_v_q  <= inj_vcnt;
    end
  end

  assign inj_en_cur = frame_start ? inj_en   : inj_en_q;
  assign inj_h_cur  = frame_start ? inj_hcnt : inj_h_q;
  assign inj_v_cur  = frame_start ? inj_vcnt : inj_v_q;
`else
  assign inj_en_cur = 1'b0;
  assign inj_h_cur  = '0;
  assign inj_v_cur  = '0;
`endif

  video_pattern_gen #(
    .WIDTH     (WIDTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_pattern_gen (
    .h       (ld_h),
    .v       (ld_v),
    .pattern (pat_cur),
    .inj_en  (inj_en_cur),
    .inj_h   (inj_h_cur),
    .inj_v   (inj_v_cur),
    .pixel   (pixel)
  );

  // Raster counters and completed-frame count advance only on accept
  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      hcnt      <= '0;
      vcnt      <= '0;
      frame_cnt <= '0;
    end else if (accept) begin
      hcnt <= h_step;
      vcnt <= v_step;
      if (last_px) begin
        frame_cnt <= frame_cnt + CNT_WIDTH'(1);
      end
    end
  end

  // Registered output stage
  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      m_axis.tvalid <= 1'b0;
      m_axis.tdata  <= '0;
      m_axis.tuser  <= 1'b0;
      m_axis.tlast  <= 1'b0;
    end else if (load) begin
      m_axis.tvalid <= 1'b1;
      m_axis.tdata  <= pixel;
      m_axis.tuser  <= (ld_h == '0) && (ld_v == '0);
      m_axis.tlast  <= (ld_h == H_LAST);
    end else if (accept) begin
      m_axis.tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axis_video_src.sv
// tb/tb_axis_video_src.sv - scoreboard bench for axis_video_src
module tb_axis_video_src;
  import dpc_video_pkg::*;

  localparam int WIDTH = 8;
  localparam int ROW   = 6;
  localparam int COL   = 8;
  localparam int CW    = 10;

  logic          axis_aclk = 1'b0;
  logic          axis_aresetn;
  logic          go;
  logic [1:0]    pattern_sel;
`ifdef DPC_SRC_DEAD_PIXEL_INJECT_EN
  logic          inj_en;
  logic [CW-1:0] inj_hcnt;
  logic [CW-1:0] inj_vcnt;
`endif
  logic [CW-1:0] frame_cnt;
  logic          busy;

  axis_video_src_if #(.WIDTH(WIDTH)) m_axis_if ();

  axis_video_src #(
    .WIDTH     (WIDTH),
    .ROW       (ROW),
    .COL       (COL),
    .CNT_WIDTH (CW)
  ) dut (
    .axis_aclk    (axis_aclk),
    .axis_aresetn (axis_aresetn),
    .go           (go),
    .pattern_sel  (pattern_sel),
`ifdef DPC_SRC_DEAD_PIXEL_INJECT_EN
    .inj_en       (inj_en),
    .inj_hcnt     (inj_hcnt),
    .inj_vcnt     (inj_vcnt),
`endif
    .m_axis       (m_axis_if),
    .frame_cnt    (frame_cnt),
    .busy         (busy)
  );

  always #5 axis_aclk = ~axis_aclk;

  int                 passed = 0;
  int                 total  = 0;
  int                 exp_frames = 0;
  logic [WIDTH+1:0]   sb[$];
  logic               hold_prev = 1'b0;
  logic [WIDTH+2:0]   held;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference pixel: {tuser, tlast, tdata}
  function automatic logic [WIDTH+1:0] model(input int h, input int v, input int pat,
                                             input bit ie, input int ih, input int iv);
    logic [WIDTH-1:0] d;
    if (ie && h == ih && v == iv) d = 8'hFF;
    else begin
      case (pat)
        0:       d = WIDTH'(h);
        1:       d = WIDTH'(v);
        2:       d = (((h ^ v) & 1) != 0) ? 8'hFF : 8'h00;
        default: d = 8'h80;
      endcase
    end
    return {(h == 0 && v == 0), (h == COL - 1), d};
  endfunction

  task automatic push_frame(input int pat, input bit ie, input int ih, input int iv);
    for (int v = 0; v < ROW; v++)
      for (int h = 0; h < COL; h++)
        sb.push_back(model(h, v, pat, ie, ih, iv));
  endtask

  function automatic logic [WIDTH+2:0] beat_now();
    return {m_axis_if.tvalid, m_axis_if.tuser, m_axis_if.tlast, m_axis_if.tdata};
  endfunction

  // Called at a negedge; mode 1 = tready always high, 2 = random tready.
  task automatic run_beats(input int n, input int mode);
    int acc = 0;
    int cyc = 0;
    logic [WIDTH+1:0] e;
    while (acc < n && cyc < 2000) begin
      m_axis_if.tready = (mode == 1) ? 1'b1 : ($urandom_range(0, 1) == 1);
      if (hold_prev) chk("hold_stable", beat_now(), held);
      if (m_axis_if.tvalid && m_axis_if.tready) begin
        chk("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk($sformatf("beat %0d {tuser,tlast,tdata}", acc),
              {m_axis_if.tuser, m_axis_if.tlast, m_axis_if.tdata}, e);
        end
        acc++;
      end
      hold_prev = m_axis_if.tvalid && !m_axis_if.tready;
      held      = beat_now();
      cyc++;
      @(negedge axis_aclk);
    end
    chk("beat_count", acc, n);
  endtask

  task automatic stall(input int n);
    repeat (n) begin
      m_axis_if.tready = 1'b0;
      if (hold_prev) chk("stall_hold", beat_now(), held);
      hold_prev = m_axis_if.tvalid;
      held      = beat_now();
      @(negedge axis_aclk);
    end
  endtask

  task automatic expect_idle(input int n);
    m_axis_if.tready = 1'b1;
    repeat (n) begin
      chk("idle_tvalid", m_axis_if.tvalid, 0);
      chk("idle_busy", busy, 0);
      @(negedge axis_aclk);
    end
    hold_prev = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_tvalid"}, m_axis_if.tvalid, 0);
    chk({tag, "_tdata"}, m_axis_if.tdata, 0);
    chk({tag, "_tuser"}, m_axis_if.tuser, 0);
    chk({tag, "_tlast"}, m_axis_if.tlast, 0);
    chk({tag, "_frame_cnt"}, frame_cnt, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    int cyc;
    axis_aresetn     = 1'b0;
    go               = 1'b0;
    pattern_sel      = 2'd0;
    m_axis_if.tready = 1'b0;
`ifdef DPC_SRC_DEAD_PIXEL_INJECT_EN
    inj_en   = 1'b0;
    inj_hcnt = '0;
    inj_vcnt = '0;
`endif
    repeat (2) @(posedge axis_aclk);
    @(negedge axis_aclk);
    chk_zero("reset");
    axis_aresetn = 1'b1;
    @(negedge axis_aclk);

    // 1: latency and one ramp frame with tready high
    m_axis_if.tready = 1'b1;
    go = 1'b1;
    push_frame(0, 0, 0, 0);
    @(negedge axis_aclk);
    chk("lat_edge1_tvalid", m_axis_if.tvalid, 0);
    @(negedge axis_aclk);
    chk("lat_edge2_tvalid", m_axis_if.tvalid, 0);
    chk("lat_edge2_busy", busy, 1);
    @(negedge axis_aclk);
    chk("lat_edge3_tvalid", m_axis_if.tvalid, 1);
    run_beats(48, 1);
    exp_frames++;
    chk("s1_frame_cnt", frame_cnt, exp_frames);

    // 2: same frame under random back-pressure
    push_frame(0, 0, 0, 0);
    run_beats(48, 2);
    exp_frames++;
    chk("s2_frame_cnt", frame_cnt, exp_frames);

    // 4: pattern switch mid-frame takes effect on the next frame only
    push_frame(0, 0, 0, 0);
    push_frame(2, 0, 0, 0);
    run_beats(10, 1);
    pattern_sel = 2'd2;
    run_beats(38, 1);
    exp_frames++;
    chk("s4_frame_cnt_a", frame_cnt, exp_frames);
    run_beats(48, 2);
    exp_frames++;
    chk("s4_frame_cnt_b", frame_cnt, exp_frames);

    // 3: go falls at beat 20; frame (already latched checker) completes then stops
    pattern_sel = 2'd0;
    push_frame(2, 0, 0, 0);
    run_beats(20, 2);
    go = 1'b0;
    run_beats(28, 2);
    exp_frames++;
    chk("s3_frame_cnt", frame_cnt, exp_frames);
    expect_idle(8);
    chk("s3_frame_cnt_after", frame_cnt, exp_frames);
    chk("s3_sb_empty", sb.size(), 0);

`ifdef DPC_SRC_DEAD_PIXEL_INJECT_EN
    // 5: flat pattern with dead pixel at (3,2)
    pattern_sel = 2'd3;
    inj_en   = 1'b1;
    inj_hcnt = CW'(3);
    inj_vcnt = CW'(2);
    go = 1'b1;
    push_frame(3, 1, 3, 2);
    run_beats(20, 1);
    go = 1'b0;
    inj_en = 1'b0;
    run_beats(28, 2);
    exp_frames++;
    chk("s5_frame_cnt", frame_cnt, exp_frames);
    expect_idle(4);
`endif

    // 6: asynchronous reset mid-frame while stalled, then clean restart
    pattern_sel = 2'd0;
    go = 1'b1;
    push_frame(0, 0, 0, 0);
    run_beats(13, 1);
    stall(3);
    #2;
    axis_aresetn = 1'b0;
    go = 1'b0;
    #1;
    chk_zero("async_reset");
    sb.delete();
    hold_prev = 1'b0;
    @(negedge axis_aclk);
    @(negedge axis_aclk);
    chk_zero("in_reset");
    axis_aresetn = 1'b1;
    @(negedge axis_aclk);
    @(negedge axis_aclk);
    go = 1'b1;
    push_frame(0, 0, 0, 0);
    cyc = 0;
    while (!m_axis_if.tvalid && cyc < 10) begin
      @(negedge axis_aclk);
      cyc++;
    end
    chk("restart_tvalid", m_axis_if.tvalid, 1);
    chk("restart_tuser", m_axis_if.tuser, 1);
    chk("restart_tdata", m_axis_if.tdata, 0);
    run_beats(20, 2);
    go = 1'b0;
    run_beats(28, 2);
    chk("s6_frame_cnt", frame_cnt, 1);
    expect_idle(4);
    chk("s6_sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
